// File: rtl/input_conditioner_if.sv
// Raw button/switch inputs and their conditioned outputs, bundled for the lab FSMs.
interface input_conditioner_if;
    logic btn_raw;
    logic sw_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic dir;
    logic dir_change;

    // Drives the raw inputs, consumes the conditioned levels and pulses.
    modport master (
        output btn_raw,
        output sw_raw,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  dir,
        input  dir_change
    );

    // The conditioner itself.
    modport slave (
        input  btn_raw,
        input  sw_raw,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output dir,
        output dir_change
    );
endinterface

// File: rtl/input_conditioner.sv
// Two-channel input conditioner: 2-flop synchronizer plus debounce FSM per channel.
// Channel 0 is the push-button, channel 1 is the direction switch.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                clk,
    input  logic                reset,
    input_conditioner_if.slave  bus
);

    localparam int unsigned N_CH = 2;

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI   = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]            raw_c;
    logic [N_CH-1:0]            sync1_q;
    logic [N_CH-1:0]            sync2_q;
    logic [N_CH-1:0][1:0]       state_q;
    logic [N_CH-1:0][1:0]       state_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;
    logic [N_CH-1:0]            level_q;
    logic [N_CH-1:0]            level_d;
    logic [N_CH-1:0]            rise_q;
    logic [N_CH-1:0]            rise_d;
    logic [N_CH-1:0]            fall_q;
    logic [N_CH-1:0]            fall_d;
    logic                       dir_change_q;

    assign raw_c = {bus.sw_raw, bus.btn_raw};

    // Two-flop synchronizer chain on each raw input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Debounce state, counter and registered level/pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= '0;
            cnt_q        <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            dir_change_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            dir_change_q <= rise_d[1] | fall_d[1];
        end
    end

    // Next-state logic: a level change is accepted only after DEBOUNCE_CYCLES agreeing samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            case (state_q[c])
                STABLE_LO: begin
                    if (sync2_q[c]) begin
                        state_d[c] = WAIT_HI;
                        cnt_d[c]   = CNT_W'(1);
                    end else begin
                        cnt_d[c]   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync2_q[c]) begin
                        state_d[c] = STABLE_LO;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == CNT_LAST) begin
                        state_d[c] = STABLE_HI;
                        cnt_d[c]   = '0;
                        level_d[c] = 1'b1;
                        rise_d[c]  = 1'b1;
                    end else begin
                        cnt_d[c]   = cnt_q[c] + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q[c]) begin
                        state_d[c] = WAIT_LO;
                        cnt_d[c]   = CNT_W'(1);
                    end else begin
                        cnt_d[c]   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync2_q[c]) begin
                        state_d[c] = STABLE_HI;
                        cnt_d[c]   = '0;
                    end else if (cnt_q[c] == CNT_LAST) begin
                        state_d[c] = STABLE_LO;
                        cnt_d[c]   = '0;
                        level_d[c] = 1'b0;
                        fall_d[c]  = 1'b1;
                    end else begin
                        cnt_d[c]   = cnt_q[c] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[c] = STABLE_LO;
                    cnt_d[c]   = '0;
                    level_d[c] = 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level  = level_q[0];
    assign bus.btn_rise   = rise_q[0];
    assign bus.btn_fall   = fall_q[0];
    assign bus.dir        = level_q[1];
    assign bus.dir_change = dir_change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a pulse scoreboard.
module tb_input_conditioner;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = N + 2;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  ev;   // {dir_change, btn_fall, btn_rise}
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned n_tests;
    int unsigned n_fail;
    exp_t        sb_q[$];

    input_conditioner_if bus();

    input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Pulse expected LAT cycles after inputs driven now (first sampling edge is E0).
    task automatic push_ev(input logic [2:0] ev);
        exp_t e;
        e.cyc = cyc + LAT;
        e.ev  = ev;
        sb_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [4:0] outs();
        return {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.dir, bus.dir_change};
    endfunction

    // Scoreboard monitor: every pulse must match the head of the queue in time and kind.
    always @(negedge clk) begin
        logic [2:0] pulses;
        exp_t       e;
        pulses = {bus.dir_change, bus.btn_fall, bus.btn_rise};
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $error("FAIL missed_pulse: observed none expected ev %b at cycle %0d", e.ev, e.cyc);
        end
        if (pulses != 3'b000) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL unexpected_pulse: observed %b at cycle %0d expected none", pulses, cyc);
            end else begin
                e = sb_q.pop_front();
                n_tests++;
                assert ({pulses, cyc} === {e.ev, e.cyc}) else begin
                    n_fail++;
                    $error("FAIL pulse: observed %b at %0d expected %b at %0d", pulses, cyc, e.ev, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [4:0] pat;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.btn_raw = 1'b1;
        bus.sw_raw  = 1'b1;

        // Reset held with raw inputs high.
        cycles(4);
        check("reset_outputs", outs(), 5'b00000);

        // Release: raw-high inputs debounce as a rise on both channels.
        reset = 1'b1;
        push_ev(3'b101);
        cycles(LAT - 1);
        check("release_before_e5", {bus.btn_level, bus.dir}, 5'b00000);
        cycles(1);
        check("release_after_e5", {bus.btn_level, bus.dir}, 5'b00011);
        cycles(14);

        // Both channels low together.
        bus.btn_raw = 1'b0;
        bus.sw_raw  = 1'b0;
        push_ev(3'b110);
        cycles(20);
        check("both_low", outs(), 5'b00000);

        // Clean press and release.
        bus.btn_raw = 1'b1;
        push_ev(3'b001);
        cycles(LAT - 1);
        check("press_before_e5", {4'b0, bus.btn_level}, 5'b00000);
        cycles(1);
        check("press_after_e5", {4'b0, bus.btn_level}, 5'b00001);
        cycles(19);
        bus.btn_raw = 1'b0;
        push_ev(3'b010);
        cycles(LAT - 1);
        check("release_btn_before_e5", {4'b0, bus.btn_level}, 5'b00001);
        cycles(1);
        check("release_btn_after_e5", {4'b0, bus.btn_level}, 5'b00000);
        cycles(19);

        // Bounce 1,0,1,1,0 then low: rejected.
        pat = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            bus.btn_raw = pat[i];
            cycles(1);
        end
        bus.btn_raw = 1'b0;
        cycles(20);
        check("bounce_rejected", outs(), 5'b00000);

        // Then a real press gives exactly one rise.
        bus.btn_raw = 1'b1;
        push_ev(3'b001);
        cycles(20);
        check("press_after_bounce", outs(), 5'b10000);

        // Three-cycle glitch low while high: ignored.
        bus.btn_raw = 1'b0;
        cycles(3);
        bus.btn_raw = 1'b1;
        cycles(20);
        check("glitch_high", outs(), 5'b10000);

        // Mid-debounce reset.
        bus.btn_raw = 1'b0;
        push_ev(3'b010);
        cycles(20);
        bus.btn_raw = 1'b1;
        cycles(3);
        reset = 1'b0;
        #1;
        check("mid_reset_outputs", outs(), 5'b00000);
        cycles(2);
        reset = 1'b1;
        push_ev(3'b001);
        cycles(LAT - 1);
        check("post_reset_before_e5", {4'b0, bus.btn_level}, 5'b00000);
        cycles(1);
        check("post_reset_after_e5", {4'b0, bus.btn_level}, 5'b00001);
        cycles(19);

        // Simultaneous channel changes.
        bus.btn_raw = 1'b0;
        push_ev(3'b010);
        cycles(20);
        bus.btn_raw = 1'b1;
        bus.sw_raw  = 1'b1;
        push_ev(3'b101);
        cycles(LAT - 1);
        check("simul_before_e5", {bus.btn_level, bus.dir}, 5'b00000);
        cycles(1);
        check("simul_after_e5", {bus.btn_level, bus.dir}, 5'b00011);
        cycles(19);
        bus.btn_raw = 1'b0;
        bus.sw_raw  = 1'b0;
        push_ev(3'b110);
        cycles(20);
        check("simul_low", outs(), 5'b00000);

        cycles(5);
        n_tests++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage for the lab FSMs (sequence detector, up/down counter). Conditions the raw push-button and the direction slide switch before they reach those FSMs.
- Per channel: 2-flop synchronizer, then a debounce state machine.
- Outputs are clean, registered levels plus single-cycle rise/fall pulses. The FSMs use the button rise pulse as a step enable and the debounced switch level as the direction input A.

Parameters:
- DEBOUNCE_CYCLES, 4: number of consecutive synchronized samples that must agree before a level change is accepted. Legal range 2..65535. Boards use a large value; simulation uses 4.
- CNT_W, 16: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all flops update on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- btn_raw  in  1  raw push-button, asynchronous to clk, bouncy.
- sw_raw  in  1  raw direction switch, asynchronous to clk, bouncy.
- btn_level  out  1  debounced button level.
- btn_rise  out  1  one-cycle pulse when btn_level goes 0->1 (step enable).
- btn_fall  out  1  one-cycle pulse when btn_level goes 1->0.
- dir  out  1  debounced switch level (FSM input A).
- dir_change  out  1  one-cycle pulse on any dir transition.

Behaviour:
- Reset (reset=0, any time, including mid-debounce):
  - synchronizer flops, counters, states and all outputs go to 0 at once;
  - FSMs return to STABLE_LO.
- Reset release: after reset returns to 1, the first rising clk edge operates normally.
- Synchronizer: s = second flop of a 2-flop chain on each raw input. No logic between the flops.
- Per-channel FSM. States: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. cnt is CNT_W bits.
  - STABLE_LO:
    - s=1 -> WAIT_HI, cnt=1;
    - else stay, cnt=0.
  - WAIT_HI:
    - s=0 -> STABLE_LO, cnt=0 (bounce rejected, no pulse);
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level=1, rise=1;
    - else cnt=cnt+1.
  - STABLE_HI and WAIT_LO: mirror image; on acceptance, level=0 and fall=1.
- Pulses: registered, exactly 1 cycle wide. Never asserted while in a WAIT state or for a rejected bounce. Rise and fall are never high in the same cycle.
- Latency: let E0 be the first edge sampling a stable new raw value. The level changes and the pulse asserts after edge E(DEBOUNCE_CYCLES+1). With N=4, that is E5.
- Counter: saturation is not possible, since it never exceeds DEBOUNCE_CYCLES-1. It clears on every return to a STABLE state.
- Channel independence: channels share no state. A simultaneous btn and sw change is handled in parallel, so btn_rise and dir_change may pulse in the same cycle.
- dir_change = rise OR fall of the switch channel.
- Raw input high at reset release: treated as a 0->1 change and debounced normally, so a rise pulse follows after N+1 edges.
- All outputs are driven directly from flops. No combinational path from raw inputs to outputs.

Test Plan:
- Reset behaviour: hold reset=0 with btn_raw=1, sw_raw=1 -> all outputs 0. Release reset -> btn_level and dir rise after edge E5; btn_rise and dir_change each pulse for exactly one cycle.
- Clean press (N=4): btn_raw 0->1 held for 20 cycles -> btn_level=1 after E5, btn_rise high for 1 cycle only. Release for 20 cycles -> btn_fall one cycle, btn_level=0 after E5.
- Bounce rejection: btn_raw pattern 1,0,1,1,0 (one cycle each), then 0 -> btn_level stays 0, no pulses, FSM back in STABLE_LO. Then hold 1 -> exactly one btn_rise.
- Glitch while high: with btn_level=1, drop btn_raw for 3 cycles, then 1 again -> btn_level stays 1, no btn_fall.
- Mid-debounce reset: btn_raw=1 and reset pulsed low after E3 -> outputs 0, cnt cleared. After reset releases, level rises only after a full N+1 edges from the first post-reset edge.
- Simultaneous channels: btn_raw and sw_raw toggle on the same edge -> btn_rise and dir_change pulse in the same cycle. Each channel's latency is unaffected by the other.
